// File: rtl/dr_addsub_hs.sv
// rtl/dr_addsub_hs.sv - N-bit dual-rail add/subtract with 4-phase handshake and registered outputs.
// Optional macro DR_ILLEGAL_CHECK_EN adds the err port and S_ERR state for 11 pairs.
module dr_addsub_hs #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [2*N-1:0] in_a,
   input  logic [2*N-1:0] in_b,
   input  logic [1:0]     cin,
   input  logic [1:0]     sub,
   output logic [2*N-1:0] soma,
   output logic [1:0]     cout,
   output logic           ack
`ifdef DR_ILLEGAL_CHECK_EN
   ,
   output logic           err
`endif
);

   localparam int P = 2*N + 2;
   localparam int W = 2*P;

`ifdef DR_ILLEGAL_CHECK_EN
   typedef enum logic [1:0] {S_NULL, S_DATA, S_ERR} state_t;
`else
   typedef enum logic [1:0] {S_NULL, S_DATA} state_t;
`endif

   state_t         r_state, w_state_nxt;
   logic [W-1:0]   r_in_q, r_in_qq;
   logic [2*N-1:0] r_soma, w_soma_nxt, w_soma_dr;
   logic [1:0]     r_cout, w_cout_nxt, w_cout_dr;
   logic           r_ack, w_ack_nxt;
   logic           w_complete, w_null, w_stable;
   logic [N-1:0]   w_a, w_b;
   logic           w_cin, w_sub;
   logic [N:0]     w_sum;
`ifdef DR_ILLEGAL_CHECK_EN
   logic           r_err, w_err_nxt, w_illegal;
`endif

   // Completion and spacer detection look only at the first sync stage.
   always_comb begin
      w_complete = 1'b1;
      w_null     = 1'b1;
`ifdef DR_ILLEGAL_CHECK_EN
      w_illegal  = 1'b0;
`endif
      for (int i = 0; i < P; i++) begin
         if (r_in_q[2*i+1] == r_in_q[2*i]) w_complete = 1'b0;
         if (r_in_q[2*i+1] | r_in_q[2*i])  w_null     = 1'b0;
`ifdef DR_ILLEGAL_CHECK_EN
         if (r_in_q[2*i+1] & r_in_q[2*i])  w_illegal  = 1'b1;
`endif
      end
   end

   assign w_stable = (r_in_q == r_in_qq);

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int i = 0; i < N; i++) begin
         w_a[i] = r_in_q[2*i+1];
         w_b[i] = r_in_q[2*N+2*i+1];
      end
   end

   assign w_cin = r_in_q[4*N+1];
   assign w_sub = r_in_q[4*N+3];
   // Subtract is A + ~B + cin; carry-out 0 then signals a borrow.
   assign w_sum = {1'b0, w_a} + {1'b0, w_b ^ {N{w_sub}}} + {{N{1'b0}}, w_cin};

   always_comb begin
      w_soma_dr = '0;
      for (int i = 0; i < N; i++) begin
         w_soma_dr[2*i+1] = w_sum[i];
         w_soma_dr[2*i]   = ~w_sum[i];
      end
   end

   assign w_cout_dr = {w_sum[N], ~w_sum[N]};

   always_comb begin
      w_state_nxt = r_state;
      w_soma_nxt  = r_soma;
      w_cout_nxt  = r_cout;
      w_ack_nxt   = r_ack;
`ifdef DR_ILLEGAL_CHECK_EN
      w_err_nxt   = r_err;
`endif
      case (r_state)
         S_NULL: begin
`ifdef DR_ILLEGAL_CHECK_EN
            if (w_illegal) begin
               w_state_nxt = S_ERR;
               w_soma_nxt  = '0;
               w_cout_nxt  = '0;
               w_ack_nxt   = 1'b0;
               w_err_nxt   = 1'b1;
            end else
`endif
            if (w_complete && w_stable) begin
               w_state_nxt = S_DATA;
               w_soma_nxt  = w_soma_dr;
               w_cout_nxt  = w_cout_dr;
               w_ack_nxt   = 1'b1;
            end
         end
         S_DATA: begin
`ifdef DR_ILLEGAL_CHECK_EN
            if (w_illegal) begin
               w_state_nxt = S_ERR;
               w_soma_nxt  = '0;
               w_cout_nxt  = '0;
               w_ack_nxt   = 1'b0;
               w_err_nxt   = 1'b1;
            end else
`endif
            if (w_null && w_stable) begin
               w_state_nxt = S_NULL;
               w_soma_nxt  = '0;
               w_cout_nxt  = '0;
               w_ack_nxt   = 1'b0;
            end
         end
`ifdef DR_ILLEGAL_CHECK_EN
         S_ERR: begin
            if (w_null && w_stable) begin
               w_state_nxt = S_NULL;
               w_err_nxt   = 1'b0;
            end
         end
`endif
         default: begin
            w_state_nxt = S_NULL;
            w_soma_nxt  = '0;
            w_cout_nxt  = '0;
            w_ack_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_NULL;
         r_in_q  <= '0;
         r_in_qq <= '0;
         r_soma  <= '0;
         r_cout  <= '0;
         r_ack   <= 1'b0;
`ifdef DR_ILLEGAL_CHECK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_in_q  <= {sub, cin, in_b, in_a};
         r_in_qq <= r_in_q;
         r_soma  <= w_soma_nxt;
         r_cout  <= w_cout_nxt;
         r_ack   <= w_ack_nxt;
`ifdef DR_ILLEGAL_CHECK_EN
         r_err   <= w_err_nxt;
`endif
      end
   end

   assign soma = r_soma;
   assign cout = r_cout;
   assign ack  = r_ack;
`ifdef DR_ILLEGAL_CHECK_EN
   assign err  = r_err;
`endif

endmodule

// File: tb/tb_dr_addsub_hs.sv
// tb/tb_dr_addsub_hs.sv - directed self-checking bench for dr_addsub_hs with N=4.
module tb_dr_addsub_hs;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_a, in_b;
   logic [1:0] cin, sub;
   logic [7:0] soma;
   logic [1:0] cout;
   logic       ack;
`ifdef DR_ILLEGAL_CHECK_EN
   logic       err;
`endif
   int checks;
   int errors;

   dr_addsub_hs #(.N(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .in_a (in_a),
      .in_b (in_b),
      .cin  (cin),
      .sub  (sub),
      .soma (soma),
      .cout (cout),
      .ack  (ack)
`ifdef DR_ILLEGAL_CHECK_EN
      ,
      .err  (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c, input logic [1:0] s);
      in_a = a; in_b = b; cin = c; sub = s;
   endtask

   task automatic expect_out(input string name, input logic [7:0] es, input logic [1:0] ec, input logic ea);
      checks++;
      if (soma !== es || cout !== ec || ack !== ea) begin
         errors++;
         $display("FAIL %s: got soma=%h cout=%b ack=%b, expected soma=%h cout=%b ack=%b",
                  name, soma, cout, ack, es, ec, ea);
      end
   endtask

   task automatic go_null(input string name);
      drive(8'h00, 8'h00, 2'b00, 2'b00);
      tick(2);
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL %s_null_early: got ack=%b expected 1", name, ack);
      end
      tick(1);
      expect_out({name, "_null"}, 8'h00, 2'b00, 1'b0);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive(8'h00, 8'h00, 2'b00, 2'b00);
      tick(2);
      expect_out("reset", 8'h00, 2'b00, 1'b0);
`ifdef DR_ILLEGAL_CHECK_EN
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
      rst_n = 1'b1;
      tick(3);
   endtask

   task automatic test_add;
      drive(8'h66, 8'h5A, 2'b01, 2'b01);
      tick(2);
      expect_out("add_latency", 8'h00, 2'b00, 1'b0);
      tick(1);
      expect_out("add", 8'h95, 2'b01, 1'b1);
      go_null("add");
   endtask

   task automatic test_sub;
      drive(8'h5A, 8'h66, 2'b10, 2'b10);
      tick(3);
      expect_out("sub_borrow", 8'hA9, 2'b01, 1'b1);
      go_null("sub");
   endtask

   task automatic test_wrap;
      drive(8'hAA, 8'h56, 2'b01, 2'b01);
      tick(3);
      expect_out("add_wrap", 8'h55, 2'b10, 1'b1);
      go_null("wrap");
   endtask

   task automatic test_skew_hold;
      drive(8'h66, 8'h00, 2'b01, 2'b01);
      tick(6);
      expect_out("skew_partial", 8'h00, 2'b00, 1'b0);
      in_b = 8'h5A;
      tick(2);
      expect_out("skew_early", 8'h00, 2'b00, 1'b0);
      tick(1);
      expect_out("skew_complete", 8'h95, 2'b01, 1'b1);
      in_a = 8'h55;
      tick(4);
      expect_out("back_to_back_hold", 8'h95, 2'b01, 1'b1);
      go_null("skew");
   endtask

   task automatic test_async_reset;
      drive(8'h5A, 8'h66, 2'b10, 2'b10);
      tick(3);
      expect_out("pre_reset", 8'hA9, 2'b01, 1'b1);
      rst_n = 1'b0;
      #1;
      expect_out("async_reset", 8'h00, 2'b00, 1'b0);
      #3;
      rst_n = 1'b1;
      tick(2);
      expect_out("post_reset_early", 8'h00, 2'b00, 1'b0);
      tick(1);
      expect_out("post_reset", 8'hA9, 2'b01, 1'b1);
      go_null("post_reset");
   endtask

   task automatic test_illegal;
      drive(8'h67, 8'h5A, 2'b01, 2'b01);
`ifdef DR_ILLEGAL_CHECK_EN
      tick(1);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL illegal_early: got err=%b expected 0", err); end
      tick(1);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got err=%b expected 1", err); end
      expect_out("illegal_out", 8'h00, 2'b00, 1'b0);
      drive(8'h00, 8'h00, 2'b00, 2'b00);
      tick(2);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL illegal_hold: got err=%b expected 1", err); end
      tick(1);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL illegal_clear: got err=%b expected 0", err); end
`else
      tick(6);
      expect_out("illegal_ignored", 8'h00, 2'b00, 1'b0);
      drive(8'h00, 8'h00, 2'b00, 2'b00);
      tick(3);
`endif
      drive(8'h66, 8'h5A, 2'b01, 2'b01);
      tick(3);
      expect_out("after_illegal", 8'h95, 2'b01, 1'b1);
      go_null("illegal");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset;
      test_add;
      test_sub;
      test_wrap;
      test_skew_hold;
      test_async_reset;
      test_illegal;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dr_addsub_hs.md
Name: dr_addsub_hs

Overview:
- Parametrised successor of the team's 4-bit dual-rail ripple adder.
- N-bit dual-rail add/subtract unit with a built-in 4-phase (return-to-zero) handshake. It detects completion, filters input skew and registers results.
- Sits at the boundary between the delay-insensitive datapath and clocked control logic. Acknowledges each DATA wavefront and waits for the NULL spacer before accepting the next one.

Parameters:
- N, 8, operand width in logical bits; every dual-rail port is 2N rails wide.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_a  in  2N  operand A, dual-rail. Bit i: true rail [2i+1], false rail [2i].
- in_b  in  2N  operand B, dual-rail, same encoding.
- cin  in  2  carry-in, dual-rail {t,f}.
- sub  in  2  mode, dual-rail: logic 0 = add, logic 1 = subtract.
- soma  out  2N  result, dual-rail, registered.
- cout  out  2  carry-out, dual-rail, registered.
- ack  out  1  acknowledge: high while DATA result is held.
- err  out  1  illegal-code flag; present only with DR_ILLEGAL_CHECK_EN.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Pair encoding {t,f}:
  - 10 = logic 1, 01 = logic 0.
  - 00 = NULL, 11 = illegal.
- Input word (in_a, in_b, cin, sub) is registered every cycle into in_q, and in_q into in_qq.
- complete = every pair of in_q is 01 or 10. null = every pair of in_q is 00.
- stable = in_q == in_qq.
- Arithmetic, modulo 2^N, with unsigned carry-out:
  - add: {c,s} = A + B + cin.
  - subtract: {c,s} = A + ~B + cin, so cin=1 gives A-B, and cout=0 means a borrow occurred.
- Output encoding: soma/cout are driven as valid dual-rail only in S_DATA. In all other states every rail is 0 (NULL).
- Reset: state=S_NULL; in_q, in_qq, soma, cout all 0; ack=0; err=0.
- FSM:
  - S_NULL: wait for complete && stable. On that edge, register soma/cout from in_q, set ack=1, go to S_DATA. Partial words (some pairs NULL) and unstable words are ignored; stay in S_NULL.
  - S_DATA: hold soma/cout/ack unchanged regardless of input changes. When null && stable, clear soma/cout to NULL, set ack=0, go to S_NULL.
- Latency: inputs settled before edge E1 → ack=1 and soma valid after edge E3. A spacer applied before edge E1 → ack=0 after edge E3.
- No combinational path from inputs to outputs.
- Back-to-back DATA without an intervening NULL is never accepted; the second word is ignored until NULL has been seen.
- Reset asserted mid-operation clears immediately and asynchronously. After release the block starts in S_NULL. If inputs are already DATA, they are accepted after two stable samples.

Optional Feature:
- Macro DR_ILLEGAL_CHECK_EN.
- Defined:
  - err port exists; state S_ERR is added.
  - Any 11 pair in in_q, from S_NULL or S_DATA, moves the block to S_ERR on that edge: err=1, ack=0, outputs NULL.
  - S_ERR exits to S_NULL only on null && stable; err clears on that edge.
- Undefined:
  - No err port and no S_ERR.
  - A word containing 11 is simply never complete, so the block waits in its current state.

Test Plan (N=4):
- Add: in_a=0x66 (5), in_b=0x5A (3), cin=01, sub=01 → after 3 edges soma=0x95 (8), cout=01, ack=1. Then all inputs 00 → 3 edges later soma=0x00, cout=00, ack=0.
- Subtract: in_a=0x5A (3), in_b=0x66 (5), cin=10, sub=10 → soma=0xA9 (14), cout=01 (borrow), ack=1.
- Wrap: in_a=0xAA (15), in_b=0x56 (1), cin=01, sub=01 → soma=0x55 (0), cout=10, ack=1.
- Skew and hold:
  - in_a valid with in_b=0x00 for 6 cycles → ack stays 0. Completing in_b → ack=1 three edges later.
  - While ack=1, changing in_a to 0x55 → soma unchanged.
- Reset: pulse rst_n low for half a cycle while in S_DATA → soma=0x00, cout=00, ack=0 immediately. With inputs still valid, ack=1 three edges after release.
- With DR_ILLEGAL_CHECK_EN: in_a pair 0 set to 11 → err=1, ack=0 two edges later. NULL inputs → err=0 three edges later.
